// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C slave
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        RX,
        TX,
        TX_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - SCL/SDA synchroniser, stability filter and bus-condition pulses
module i2c_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

    // Bit 0 carries SCL, bit 1 carries SDA; both lines idle high out of reset.
    logic [1:0]      sync1, sync2, filt, filt_d;
    logic [1:0][3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            cnt    <= '0;
        end else begin
            sync1  <= {sda_in, scl_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign sda_f     = filt[1];
    assign scl_rise  = filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] & filt_d[0];
    // Judged against the current SCL level so a simultaneous SCL rise still yields START.
    assign start_det = filt[0] & filt_d[1] & ~filt[1];
    assign stop_det  = filt[0] & ~filt_d[1] & filt[1];

endmodule

// File: rtl/i2c_slave_regfile_ctrl.sv
// rtl/i2c_slave_regfile_ctrl.sv - oversampled I2C slave with pointer-addressed register-file port
module i2c_slave_regfile_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h48,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned AUTO_INC   = 1,
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic          reg_wr,
    output logic [7:0]    reg_wdata,
    output logic          reg_rd,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          addr_hit
);

    logic sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_f     (sda_f),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e    state, state_next;
    logic [7:0]    shift, shift_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic          in_ack, in_ack_n;
    logic          rw, rw_n;
    logic [AW-1:0] ptr, ptr_n, ptr_inc;
    logic          rd_pend;
    logic [AW-1:0] reg_addr_n;
    logic [7:0]    reg_wdata_n;
    logic          sda_oe_n, reg_wr_n, reg_rd_n, busy_n, addr_hit_n;
    logic          bit_in, byte_done, ack_end;

    assign ptr_inc   = (ptr == AW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
    assign bit_in    = scl_rise && !in_ack && (bit_cnt != 4'd8);
    assign byte_done = scl_fall && !in_ack && (bit_cnt == 4'd8);
    assign ack_end   = scl_fall && in_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            in_ack    <= 1'b0;
            rw        <= I2C_WRITE;
            ptr       <= '0;
            rd_pend   <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            in_ack    <= in_ack_n;
            rw        <= rw_n;
            ptr       <= ptr_n;
            rd_pend   <= reg_rd;
            sda_oe    <= sda_oe_n;
            reg_addr  <= reg_addr_n;
            reg_wr    <= reg_wr_n;
            reg_wdata <= reg_wdata_n;
            reg_rd    <= reg_rd_n;
            busy      <= busy_n;
            addr_hit  <= addr_hit_n;
        end
    end

    always_comb begin
        state_next  = state;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        in_ack_n    = in_ack;
        rw_n        = rw;
        ptr_n       = ptr;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        reg_wr_n    = 1'b0;
        reg_rd_n    = 1'b0;
        addr_hit_n  = 1'b0;

        if (rd_pend) begin
            shift_n = reg_rdata;
        end

        if (stop_det) begin
            state_next = IDLE;
            sda_oe_n   = 1'b0;
            busy_n     = 1'b0;
        end else if (start_det) begin
            state_next = ADDR;
            sda_oe_n   = 1'b0;
            busy_n     = 1'b1;
            bit_cnt_n  = '0;
            in_ack_n   = 1'b0;
        end else begin
            if (bit_in && (state == ADDR || state == PTR || state == RX)) begin
                shift_n   = {shift[6:0], sda_f};
                bit_cnt_n = bit_cnt + 4'd1;
            end
            case (state)
                IDLE: ;
                ADDR: begin
                    if (byte_done) begin
                        if (shift[7:1] == SLAVE_ADDR) begin
                            addr_hit_n = 1'b1;
                            sda_oe_n   = 1'b1;
                            rw_n       = shift[0];
                            state_next = ADDR_ACK;
                        end else begin
                            sda_oe_n   = 1'b0;
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    // Read data is fetched during the ACK clock so bit 7 is ready on its falling edge.
                    if (scl_rise && rw == I2C_READ) begin
                        reg_rd_n   = 1'b1;
                        reg_addr_n = ptr;
                        bit_cnt_n  = '0;
                        state_next = TX;
                    end else if (scl_fall && rw == I2C_WRITE) begin
                        sda_oe_n   = 1'b0;
                        bit_cnt_n  = '0;
                        state_next = PTR;
                    end
                end
                PTR: begin
                    if (byte_done) begin
                        if ({1'b0, shift} < 9'(NUM_REGS)) begin
                            ptr_n      = shift[AW-1:0];
                            sda_oe_n   = 1'b1;
                            in_ack_n   = 1'b1;
                            state_next = RX;
                        end else begin
                            sda_oe_n   = 1'b0;
                            state_next = IGNORE;
                        end
                    end
                end
                RX: begin
                    if (ack_end) begin
                        sda_oe_n  = 1'b0;
                        in_ack_n  = 1'b0;
                        bit_cnt_n = '0;
                    end else if (byte_done) begin
                        reg_wr_n    = 1'b1;
                        reg_addr_n  = ptr;
                        reg_wdata_n = shift;
                        sda_oe_n    = 1'b1;
                        in_ack_n    = 1'b1;
                        if (AUTO_INC != 0) begin
                            ptr_n = ptr_inc;
                        end
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n   = 1'b0;
                            state_next = TX_ACK;
                        end else begin
                            sda_oe_n  = ~shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_f == ACK) begin
                            ptr_n      = ptr_inc;
                            reg_addr_n = ptr_inc;
                            reg_rd_n   = 1'b1;
                            bit_cnt_n  = '0;
                            state_next = TX;
                        end else if (sda_f == NACK) begin
                            state_next = IGNORE;
                        end
                    end
                end
                IGNORE: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                    sda_oe_n   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile_ctrl.sv
// tb/tb_i2c_slave_regfile_ctrl.sv - directed bus-level bench for i2c_slave_regfile_ctrl
module tb_i2c_slave_regfile_ctrl;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, reg_wr, reg_rd, busy, addr_hit;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;
    logic [7:0] mem [16];

    int checks = 0;
    int failures = 0;

    logic [11:0] wr_log [$];
    logic [3:0]  rd_log [$];
    int          hit_cnt = 0;
    int          oe_cnt = 0;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = mem[reg_addr];

    i2c_slave_regfile_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .addr_hit  (addr_hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
            if (reg_rd) rd_log.push_back(reg_addr);
            if (addr_hit) hit_cnt++;
            if (sda_oe) oe_cnt++;
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(Q);
        s = sda_line;
        wait_cyc(Q);
        scl_m = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(1'b1, d[i]);
        bit_cycle(ack, s);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(2 * Q);
        sda_m = 1'b0;
        wait_cyc(2 * Q);
        scl_m = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(2 * Q);
        sda_m = 1'b1;
        wait_cyc(2 * Q);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_cyc(4);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (reg_wr !== 1'b0) begin failures++; $display("FAIL reset_reg_wr: got %b expected 0", reg_wr); end
        checks++; if (reg_rd !== 1'b0) begin failures++; $display("FAIL reset_reg_rd: got %b expected 0", reg_rd); end
        checks++; if (reg_addr !== 4'h0) begin failures++; $display("FAIL reset_reg_addr: got %h expected 0", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_reg_wdata: got %h expected 00", reg_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (addr_hit !== 1'b0) begin failures++; $display("FAIL reset_addr_hit: got %b expected 0", addr_hit); end
        rst_n = 1'b1;
        wait_cyc(10);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_burst();
        logic a0, a1, a2, a3;
        int wb, rb, hb;
        wb = wr_log.size(); rb = rd_log.size(); hb = hit_cnt;
        i2c_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_start: got %b expected 1", busy); end
        send_byte(8'h90, a0);
        send_byte(8'h03, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h5A, a3);
        i2c_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL wr_acks: got %b expected 0000", {a0, a1, a2, a3}); end
        checks++; if (wr_log.size() - wb !== 2) begin failures++; $display("FAIL wr_count: got %0d expected 2", wr_log.size() - wb); end
        checks++; if (wr_log[wb] !== 12'h3A5) begin failures++; $display("FAIL wr_first: got %h expected 3a5", wr_log[wb]); end
        checks++; if (wr_log[wb + 1] !== 12'h45A) begin failures++; $display("FAIL wr_second: got %h expected 45a", wr_log[wb + 1]); end
        checks++; if (rd_log.size() - rb !== 0) begin failures++; $display("FAIL wr_no_read: got %0d expected 0", rd_log.size() - rb); end
        checks++; if (hit_cnt - hb !== 1) begin failures++; $display("FAIL wr_addr_hit: got %0d expected 1", hit_cnt - hb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_combined_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int rb;
        rb = rd_log.size();
        i2c_start();
        send_byte(8'h90, a0);
        send_byte(8'h0F, a1);
        i2c_start();
        send_byte(8'h91, a2);
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rd_release_after_nack: got %b expected 0", sda_oe); end
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rd_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'hC3) begin failures++; $display("FAIL rd_byte0: got %h expected c3", d0); end
        checks++; if (d1 !== 8'h3C) begin failures++; $display("FAIL rd_byte1_wrap: got %h expected 3c", d1); end
        checks++; if (rd_log.size() - rb !== 2) begin failures++; $display("FAIL rd_count: got %0d expected 2", rd_log.size() - rb); end
        checks++; if (rd_log[rb] !== 4'hF) begin failures++; $display("FAIL rd_addr0: got %h expected f", rd_log[rb]); end
        checks++; if (rd_log[rb + 1] !== 4'h0) begin failures++; $display("FAIL rd_addr1: got %h expected 0", rd_log[rb + 1]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        int wb, rb, hb, ob;
        wb = wr_log.size(); rb = rd_log.size(); hb = hit_cnt; ob = oe_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h03, a1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mm_busy_ignore: got %b expected 1", busy); end
        i2c_stop();
        checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL mm_nacks: got %b expected 11", {a0, a1}); end
        checks++; if (oe_cnt - ob !== 0) begin failures++; $display("FAIL mm_sda_oe: got %0d cycles expected 0", oe_cnt - ob); end
        checks++; if ((wr_log.size() - wb) + (rd_log.size() - rb) !== 0) begin failures++; $display("FAIL mm_no_access: got %0d expected 0", (wr_log.size() - wb) + (rd_log.size() - rb)); end
        checks++; if (hit_cnt - hb !== 0) begin failures++; $display("FAIL mm_addr_hit: got %0d expected 0", hit_cnt - hb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mm_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_ptr_range();
        logic a0, a1, a2;
        int wb;
        wb = wr_log.size();
        i2c_start();
        send_byte(8'h90, a0);
        send_byte(8'h20, a1);
        send_byte(8'h11, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b011) begin failures++; $display("FAIL ptr_range_acks: got %b expected 011", {a0, a1, a2}); end
        checks++; if (wr_log.size() - wb !== 0) begin failures++; $display("FAIL ptr_range_no_write: got %0d expected 0", wr_log.size() - wb); end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, a2, a3, s;
        int wb;
        wb = wr_log.size();
        i2c_start();
        send_byte(8'h90, a0);
        send_byte(8'h07, a1);
        for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
        i2c_stop();
        checks++; if (wr_log.size() - wb !== 0) begin failures++; $display("FAIL stop_mid_no_write: got %0d expected 0", wr_log.size() - wb); end
        checks++; if ({busy, sda_oe} !== 2'b00) begin failures++; $display("FAIL stop_mid_idle: got busy,oe=%b expected 00", {busy, sda_oe}); end
        i2c_start();
        send_byte(8'h90, a2);
        send_byte(8'h07, a3);
        send_byte(8'h77, a0);
        i2c_stop();
        checks++; if ({a2, a3, a0} !== 3'b000) begin failures++; $display("FAIL stop_mid_next_acks: got %b expected 000", {a2, a3, a0}); end
        checks++; if (wr_log.size() - wb !== 1 || wr_log[wb] !== 12'h777) begin failures++; $display("FAIL stop_mid_next_write: got %0d entries first %h expected 1 entry 777", wr_log.size() - wb, wr_log[wb]); end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2, s;
        logic [7:0] d;
        int wb, hb;
        wb = wr_log.size(); hb = hit_cnt;
        sda_m = 1'b0; wait_cyc(1); sda_m = 1'b1; wait_cyc(12);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_start_1cyc: got busy %b expected 0", busy); end
        sda_m = 1'b0; wait_cyc(2); sda_m = 1'b1; wait_cyc(12);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_start_2cyc: got busy %b expected 0", busy); end
        i2c_start();
        send_byte(8'h90, a0);
        send_byte(8'h09, a1);
        d = 8'h3C;
        sda_m = 1'b0;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(3);
        sda_m = 1'b1; wait_cyc(1); sda_m = 1'b0;
        wait_cyc(12);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_stop_busy: got %b expected 1", busy); end
        scl_m = 1'b0;
        wait_cyc(Q);
        for (int i = 6; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL glitch_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (wr_log.size() - wb !== 1 || wr_log[wb] !== 12'h93C) begin failures++; $display("FAIL glitch_write: got %0d entries first %h expected 1 entry 93c", wr_log.size() - wb, wr_log[wb]); end
        checks++; if (hit_cnt - hb !== 1) begin failures++; $display("FAIL glitch_addr_hit: got %0d expected 1", hit_cnt - hb); end
    endtask

    task automatic test_async_reset();
        logic s;
        logic [7:0] d;
        d = 8'h90;
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL areset_pre_ack: got %b expected 1", sda_oe); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({sda_oe, busy} !== 2'b00) begin failures++; $display("FAIL areset_release: got oe,busy=%b expected 00", {sda_oe, busy}); end
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(12);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
        mem[15] = 8'hC3;
        mem[0]  = 8'h3C;
        test_reset();
        test_write_burst();
        test_combined_read();
        test_addr_mismatch();
        test_ptr_range();
        test_stop_mid_byte();
        test_glitch();
        test_async_reset();
        test_write_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
